sram_ctrl: RTL and testbench

Synchronous controller for the external 128K×8 asynchronous SRAM (AS6C1008) on the TinyFPGA BX. It accepts single-byte read and write requests from FPGA logic over a valid/ready handshake and drives the chip's address, data, CE#, OE# and WE# pins. Each access is sequenced with cycle counters so that the datasheet read-cycle and write-pulse minimums are met. It sits between user logic and the top-level pin/tristate wrapper.

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_wait_counter.sv | 39 +++
 rtl/sram_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the AS6C1008 SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 17;
  localparam int SRAM_DW = 8;

  // Inactive levels of the SRAM control pins.
  localparam logic CE_N_IDLE = 1'b1;
  localparam logic OE_N_IDLE = 1'b1;
  localparam logic WE_N_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ACCESS = 3'd1,
    ST_RD_DONE   = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_PULSE  = 3'd4,
    ST_WR_HOLD   = 3'd5
  } state_e;

  // Larger of two integers, used to size the shared wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter used to time both the read access and the WE# pulse.
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: a load wins over a decrement; decrementing stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/sram_ctrl.sv
// Single-byte valid/ready front end for the external 128Kx8 asynchronous SRAM.
// All SRAM pins come straight from flops; next pin levels are decoded from the
// next state so each pin changes on the same edge as the state.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [SRAM_AW-1:0] req_addr,
  input  logic [SRAM_DW-1:0] req_wdata,
  output logic [SRAM_DW-1:0] rdata,
  output logic               rvalid,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_ce2,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int CW = $clog2(max_int(RD_CYCLES, WP_CYCLES) + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WP_LOAD = CW'(WP_CYCLES - 1);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               rvalid_q, rvalid_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic [SRAM_DW-1:0] rdata_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] dq_q;

  logic               accept;
  logic               capture;
  logic               cnt_load;
  logic [CW-1:0]      cnt_load_val;
  logic               cnt_dec;
  logic               cnt_zero;

  sram_wait_counter #(.W(CW)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Sequencing: next state, counter control, request acceptance and read capture.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = {CW{1'b0}};
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          accept = 1'b1;
          if (req_write) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d      = ST_RD_ACCESS;
            cnt_load     = 1'b1;
            cnt_load_val = RD_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ACCESS: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = ST_RD_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RD_DONE: begin
        state_d = ST_IDLE;
      end
      ST_WR_SETUP: begin
        state_d      = ST_WR_PULSE;
        cnt_load     = 1'b1;
        cnt_load_val = WP_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin and handshake levels for the cycle that follows, decoded from the next state.
  always_comb begin
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    ce_n_d   = CE_N_IDLE;
    oe_n_d   = OE_N_IDLE;
    we_n_d   = WE_N_IDLE;
    dq_oe_d  = 1'b0;
    case (state_d)
      ST_IDLE: begin
        ready_d = 1'b1;
      end
      ST_RD_ACCESS: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      ST_RD_DONE: begin
        rvalid_d = 1'b1;
      end
      ST_WR_SETUP: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      ST_WR_PULSE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      ST_WR_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // State, output pins, latched request and read data; reset returns all to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      ce_n_q   <= CE_N_IDLE;
      oe_n_q   <= OE_N_IDLE;
      we_n_q   <= WE_N_IDLE;
      dq_oe_q  <= 1'b0;
      rdata_q  <= {SRAM_DW{1'b0}};
      addr_q   <= {SRAM_AW{1'b0}};
      dq_q     <= {SRAM_DW{1'b0}};
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
      if (accept) begin
        addr_q <= req_addr;
        dq_q   <= req_wdata;
      end
      if (capture) begin
        rdata_q <= sram_dq_in;
      end
    end
  end

  assign req_ready   = ready_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_ce2    = 1'b1;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: instance 0 uses RD_CYCLES=2/WP_CYCLES=1, instance 1 uses 4/3.
// Each instance drives its own behavioural SRAM; expected data comes from a
// per-instance byte map updated at request level.
module tb_sram_ctrl;

  logic        clk;
  logic        rst    [2];
  logic        valid  [2];
  logic        write  [2];
  logic [16:0] addr   [2];
  logic [7:0]  wdata  [2];
  logic        ready  [2];
  logic        rvalid [2];
  logic [7:0]  rdata  [2];
  logic [16:0] saddr  [2];
  logic [7:0]  dq_out [2];
  logic [7:0]  dq_in  [2];
  logic        dq_oe  [2];
  logic        ce_n   [2];
  logic        ce2    [2];
  logic        oe_n   [2];
  logic        we_n   [2];

  int n_checks = 0;
  int n_errors = 0;

  sram_ctrl #(.RD_CYCLES(2), .WP_CYCLES(1)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_write(write[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
    .rdata(rdata[0]), .rvalid(rvalid[0]), .sram_addr(saddr[0]),
    .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]),
    .sram_ce_n(ce_n[0]), .sram_ce2(ce2[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]));

  sram_ctrl #(.RD_CYCLES(4), .WP_CYCLES(3)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_write(write[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
    .rdata(rdata[1]), .rvalid(rvalid[1]), .sram_addr(saddr[1]),
    .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]),
    .sram_ce_n(ce_n[1]), .sram_ce2(ce2[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural AS6C1008 chips: drive DQ only while selected and output-enabled.
  logic [7:0] mem0 [0:131071];
  logic [7:0] mem1 [0:131071];
  assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? mem0[saddr[0]] : 8'hEE;
  assign dq_in[1] = (!ce_n[1] && !oe_n[1]) ? mem1[saddr[1]] : 8'hEE;

  // Chip write: byte is stored while CE# and WE# are both low.
  always @(posedge clk) begin
    if (!ce_n[0] && !we_n[0]) mem0[saddr[0]] <= dq_out[0];
    if (!ce_n[1] && !we_n[1]) mem1[saddr[1]] <= dq_out[1];
  end

  // Reference contents, keyed by address.
  logic [7:0]  refm0 [int];
  logic [7:0]  refm1 [int];
  logic [16:0] wq0 [$];
  logic [16:0] wq1 [$];
  logic [7:0]  rq0 [$];

  function automatic int rdc(input int s);
    return (s == 0) ? 2 : 4;
  endfunction

  function automatic int wpc(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] ref_get(input int s, input logic [16:0] a);
    if (s == 0) return refm0.exists(int'(a)) ? refm0[int'(a)] : 8'h00;
    else        return refm1.exists(int'(a)) ? refm1[int'(a)] : 8'h00;
  endfunction

  task automatic ref_set(input int s, input logic [16:0] a, input logic [7:0] d);
    if (s == 0) refm0[int'(a)] = d;
    else        refm1[int'(a)] = d;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bus monitor state.
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          we_run  [2] = '{0, 0};
  int          oe_run  [2] = '{0, 0};
  int          last_we [2] = '{0, 0};
  int          last_oe [2] = '{0, 0};
  int          rv_cnt  [2] = '{0, 0};
  logic [16:0] prev_addr [2];
  logic [7:0]  prev_dq   [2];

  // Per-cycle bus checks at the falling edge: contention, WE# window stability, pulse widths.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int s = 0; s < 2; s++) begin
        if (mon_en && rst[s]) begin
          we_run[s] = 0;
          oe_run[s] = 0;
        end else if (mon_en) begin
          chk_eq("bus_contention", 32'(dq_oe[s] & ~oe_n[s]), 32'd0);
          if (!we_n[s]) begin
            chk_eq("we_oe_high", 32'(oe_n[s]), 32'd1);
            if (we_run[s] == 0) chk_eq("we_addr_setup", 32'(saddr[s]), 32'(prev_addr[s]));
            else begin
              chk_eq("we_addr_stable", 32'(saddr[s]), 32'(prev_addr[s]));
              chk_eq("we_data_stable", 32'(dq_out[s]), 32'(prev_dq[s]));
            end
            we_run[s]++;
          end else if (we_run[s] > 0) begin
            chk_eq("wr_data_hold", 32'({dq_oe[s], dq_out[s]}), 32'({1'b1, prev_dq[s]}));
            last_we[s] = we_run[s];
            we_run[s]  = 0;
          end
          if (!oe_n[s]) oe_run[s]++;
          else if (oe_run[s] > 0) begin
            last_oe[s] = oe_run[s];
            oe_run[s]  = 0;
          end
          if (rvalid[s]) begin
            rv_cnt[s]++;
            if (s == 0) rq0.push_back(rdata[0]);
          end
        end
        prev_addr[s] = saddr[s];
        prev_dq[s]   = dq_out[s];
      end
    end
  end

  // One request with timing checks. Ready rises after edge N+WP+2 (seen at the
  // 4th falling edge for WP=1); rvalid is seen at falling edge RD+1 after accept.
  task automatic do_req(input int s, input bit wr, input logic [16:0] a, input logic [7:0] d);
    int t;
    int lat;
    logic [7:0] exp;
    @(negedge clk);
    valid[s] = 1'b1; write[s] = wr; addr[s] = a; wdata[s] = d;
    t = 0;
    while (!ready[s] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready[s]) begin
      chk_eq("accept_timeout", 32'(ready[s]), 32'd1);
      valid[s] = 1'b0;
      return;
    end
    last_we[s] = 0;
    last_oe[s] = 0;
    exp = ref_get(s, a);
    @(posedge clk);
    #1;
    valid[s] = 1'b0; write[s] = 1'($urandom); addr[s] = 17'($urandom); wdata[s] = 8'($urandom);
    lat = 0;
    if (wr) begin
      do begin @(negedge clk); lat++; end while (!ready[s] && lat < 50);
      #1;
      chk_eq("wr_occupancy", 32'(lat), 32'(wpc(s) + 3));
      chk_eq("we_low_cycles", 32'(last_we[s]), 32'(wpc(s)));
      ref_set(s, a, d);
    end else begin
      do begin @(negedge clk); lat++; end while (!rvalid[s] && lat < 50);
      #1;
      chk_eq("rd_latency", 32'(lat), 32'(rdc(s) + 1));
      chk_eq("rd_data", 32'(rdata[s]), 32'(exp));
      chk_eq("oe_low_cycles", 32'(last_oe[s]), 32'(rdc(s)));
      @(negedge clk);
      #1;
      chk_eq("rvalid_one_cycle", 32'(rvalid[s]), 32'd0);
      chk_eq("ready_after_rvalid", 32'(ready[s]), 32'd1);
      chk_eq("rdata_held", 32'(rdata[s]), 32'(exp));
    end
  endtask

  // Four alternating requests with req_valid held high throughout.
  task automatic back_to_back();
    bit          ops_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [16:0] ops_a [4];
    logic [7:0]  ops_d [4];
    int          acc   [4];
    int          idx = 0;
    int          t = 0;
    ops_a[0] = 17'h01234; ops_a[1] = 17'h01234; ops_a[2] = 17'h1ABCD; ops_a[3] = 17'h1ABCD;
    ops_d[0] = 8'($urandom); ops_d[1] = 8'h00; ops_d[2] = 8'($urandom); ops_d[3] = 8'h00;
    rq0.delete();
    @(negedge clk);
    valid[0] = 1'b1; write[0] = ops_w[0]; addr[0] = ops_a[0]; wdata[0] = ops_d[0];
    while (idx < 4 && t < 100) begin
      if (ready[0]) begin
        @(posedge clk);
        acc[idx] = cyc;
        #1;
        idx++;
        if (idx < 4) begin
          write[0] = ops_w[idx]; addr[0] = ops_a[idx]; wdata[0] = ops_d[idx];
        end else begin
          valid[0] = 1'b0;
        end
      end
      @(negedge clk);
      t++;
    end
    valid[0] = 1'b0;
    chk_eq("b2b_accepted", 32'(idx), 32'd4);
    repeat (8) @(negedge clk);
    #1;
    if (idx == 4) begin
      for (int i = 0; i < 3; i++)
        chk_eq("b2b_spacing", 32'(acc[i+1] - acc[i]), ops_w[i] ? 32'(wpc(0) + 3) : 32'(rdc(0) + 2));
    end
    chk_eq("b2b_reads", 32'(rq0.size()), 32'd2);
    if (rq0.size() == 2) begin
      chk_eq("b2b_rd0", 32'(rq0[0]), 32'(ops_d[0]));
      chk_eq("b2b_rd1", 32'(rq0[1]), 32'(ops_d[2]));
    end
    ref_set(0, ops_a[0], ops_d[0]);
    ref_set(0, ops_a[2], ops_d[2]);
  endtask

  // Issue a request and return just after its acceptance edge.
  task automatic start_req(input bit wr, input logic [16:0] a, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    valid[0] = 1'b1; write[0] = wr; addr[0] = a; wdata[0] = d;
    while (!ready[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk_eq("start_ready", 32'(ready[0]), 32'd1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int          s;
    bit          wr;
    int          k;
    int          rvc;
    logic [16:0] a;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; write[i] = 1'b0; addr[i] = 17'h0; wdata[i] = 8'h0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_eq("rst_ready", 32'(ready[i]), 32'd0);
      chk_eq("rst_rvalid_rdata", 32'({rvalid[i], rdata[i]}), 32'd0);
      chk_eq("rst_addr_dq", 32'({saddr[i], dq_out[i]}), 32'd0);
      chk_eq("rst_pins", 32'({ce2[i], ce_n[i], oe_n[i], we_n[i], dq_oe[i]}), 32'b11110);
    end
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_init", 32'({ready[0], ready[1]}), 32'b11);
    mon_en = 1'b1;

    // Write then read.
    do_req(0, 1'b1, 17'h00010, 8'hA5);
    do_req(0, 1'b0, 17'h00010, 8'h00);

    // Address extremes.
    do_req(0, 1'b1, 17'h1FFFF, 8'h3C);
    do_req(0, 1'b1, 17'h00000, 8'hC3);
    do_req(0, 1'b0, 17'h1FFFF, 8'h00);
    do_req(0, 1'b0, 17'h00000, 8'h00);

    back_to_back();

    // Longer read and write windows on the second instance.
    do_req(1, 1'b1, 17'h0F0F0, 8'h5A);
    do_req(1, 1'b0, 17'h0F0F0, 8'h00);

    // Random traffic on both instances; reads only from written addresses.
    for (int i = 0; i < 30; i++) begin
      s  = i % 2;
      wr = ($urandom_range(0, 2) == 0) || (s == 0 ? wq0.size() == 0 : wq1.size() == 0);
      if (wr) begin
        a = 17'($urandom);
        if (s == 0) wq0.push_back(a); else wq1.push_back(a);
        do_req(s, 1'b1, a, 8'($urandom));
      end else begin
        if (s == 0) begin k = $urandom_range(0, wq0.size() - 1); a = wq0[k]; end
        else        begin k = $urandom_range(0, wq1.size() - 1); a = wq1[k]; end
        do_req(s, 1'b0, a, 8'($urandom));
      end
    end

    // Reset during the read access phase.
    do_req(0, 1'b1, 17'h00777, 8'h77);
    do_req(0, 1'b0, 17'h00777, 8'h00);
    rvc = rv_cnt[0];
    start_req(1'b0, 17'h00777, 8'h00);
    @(negedge clk);
    chk_eq("pre_rst_oe_low", 32'(oe_n[0]), 32'd0);
    #1 rst[0] = 1'b1;
    @(negedge clk);
    #1 rst[0] = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk_eq("rst_rd_no_rvalid", 32'(rv_cnt[0]), 32'(rvc));
    chk_eq("rst_rd_rdata", 32'(rdata[0]), 32'd0);
    chk_eq("rst_rd_idle", 32'({ready[0], oe_n[0], ce_n[0]}), 32'b111);

    // Reset during the WE# pulse.
    rvc = rv_cnt[0];
    start_req(1'b1, 17'h0ABCD, 8'h99);
    @(negedge clk);
    @(negedge clk);
    chk_eq("pre_rst_we_low", 32'(we_n[0]), 32'd0);
    #1 rst[0] = 1'b1;
    @(negedge clk);
    chk_eq("rst_wr_pins", 32'({we_n[0], ce_n[0], dq_oe[0], ready[0]}), 32'b1100);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    chk_eq("rst_wr_ready", 32'(ready[0]), 32'd1);
    repeat (4) @(negedge clk);
    chk_eq("rst_wr_no_rvalid", 32'(rv_cnt[0]), 32'(rvc));
    chk_eq("rst_wr_we_high", 32'(we_n[0]), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
